// File: rtl/audio_feed_clk_pkg.sv
// rtl/audio_feed_clk_pkg.sv - shared types, limits and helpers for the audio feed clock-enable generator
package audio_feed_clk_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    APPLY  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int MIN_OUTPUTS   = 1;
  localparam int MAX_OUTPUTS   = 16;
  localparam int MIN_ACC_WIDTH = 8;
  localparam int MAX_ACC_WIDTH = 48;

  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_feed_nco_chan.sv
// rtl/audio_feed_nco_chan.sv - one phase-accumulator NCO channel with registered strobe and square wave
module audio_feed_nco_chan #(
  parameter int ACC_WIDTH = 32,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INCR  = {1'b1, {(ACC_WIDTH-1){1'b0}}},
  parameter logic [ACC_WIDTH-1:0] DEFAULT_PHASE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] load_incr,
  input  logic [ACC_WIDTH-1:0] load_phase,
  output logic                 strobe,
  output logic                 msb
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] incr;
  logic [ACC_WIDTH-1:0] acc_cur;
  logic [ACC_WIDTH-1:0] incr_cur;
  logic [ACC_WIDTH:0]   sum;

  // A load makes the captured phase the accumulator value for this cycle.
  always_comb begin
    acc_cur  = load ? load_phase : acc;
    incr_cur = load ? load_incr  : incr;
    sum      = {1'b0, acc_cur} + {1'b0, incr_cur};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= DEFAULT_PHASE;
      incr   <= DEFAULT_INCR;
      strobe <= 1'b0;
      msb    <= 1'b0;
    end else begin
      acc    <= sum[ACC_WIDTH-1:0];
      incr   <= incr_cur;
      strobe <= sum[ACC_WIDTH] & ~load;
      msb    <= acc_cur[ACC_WIDTH-1];
    end
  end

endmodule

// File: rtl/audio_feed_clk_en_gen.sv
// rtl/audio_feed_clk_en_gen.sv - multi-channel NCO clock-enable generator with settle/lock sequencer
module audio_feed_clk_en_gen
  import audio_feed_clk_pkg::*;
#(
  parameter int NUM_OUTPUTS = 3,
  parameter int ACC_WIDTH   = 32,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_OUTPUTS*ACC_WIDTH-1:0] DEFAULT_INCR =
    {NUM_OUTPUTS{{1'b1, {(ACC_WIDTH-1){1'b0}}}}},
  parameter logic [NUM_OUTPUTS*ACC_WIDTH-1:0] DEFAULT_PHASE = '0,
  localparam int CHW = chan_w(NUM_OUTPUTS)
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CHW-1:0]         cfg_chan,
  input  logic [ACC_WIDTH-1:0]   cfg_incr,
  input  logic [ACC_WIDTH-1:0]   cfg_phase,
  output logic [NUM_OUTPUTS-1:0] outclk_en,
  output logic [NUM_OUTPUTS-1:0] outclk,
  output logic                   locked
);

  localparam int CNT_W = chan_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [CHW-1:0]       cap_chan;
  logic [ACC_WIDTH-1:0] cap_incr;
  logic [ACC_WIDTH-1:0] cap_phase;
  logic                 chan_ok;
  logic                 accept_apply;

  // Out-of-range channels are still handshaken so a bad request never stalls the master.
  assign chan_ok      = (32'(cfg_chan) < NUM_OUTPUTS);
  assign accept_apply = cfg_valid && cfg_ready && chan_ok;

  always_ff @(posedge refclk) begin
    if (rst) state <= SETTLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SETTLE: begin
        if (accept_apply)          state_next = APPLY;
        else if (cnt == CNT_LAST)  state_next = LOCKED;
      end
      APPLY:  state_next = SETTLE;
      LOCKED: if (accept_apply) state_next = APPLY;
      default: state_next = SETTLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state != APPLY);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt       <= '0;
      locked    <= 1'b0;
      cap_chan  <= '0;
      cap_incr  <= '0;
      cap_phase <= '0;
    end else begin
      locked <= (state_next == LOCKED);
      if (state == SETTLE && state_next == SETTLE) cnt <= cnt + CNT_W'(1);
      else                                         cnt <= '0;
      if (accept_apply) begin
        cap_chan  <= cfg_chan;
        cap_incr  <= cfg_incr;
        cap_phase <= cfg_phase;
      end
    end
  end

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_chan
    audio_feed_nco_chan #(
      .ACC_WIDTH    (ACC_WIDTH),
      .DEFAULT_INCR (DEFAULT_INCR[i*ACC_WIDTH +: ACC_WIDTH]),
      .DEFAULT_PHASE(DEFAULT_PHASE[i*ACC_WIDTH +: ACC_WIDTH])
    ) u_chan (
      .clk       (refclk),
      .rst       (rst),
      .load      ((state == APPLY) && (cap_chan == CHW'(i))),
      .load_incr (cap_incr),
      .load_phase(cap_phase),
      .strobe    (outclk_en[i]),
      .msb       (outclk[i])
    );
  end

endmodule

// File: tb/tb_audio_feed_clk_en_gen.sv
// tb/tb_audio_feed_clk_en_gen.sv - scoreboard bench for audio_feed_clk_en_gen
module tb_audio_feed_clk_en_gen;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int LC = 16;

  logic         refclk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [1:0]   cfg_chan = '0;
  logic [W-1:0] cfg_incr = '0;
  logic [W-1:0] cfg_phase = '0;
  logic [N-1:0] outclk_en;
  logic [N-1:0] outclk;
  logic         locked;

  audio_feed_clk_en_gen #(
    .NUM_OUTPUTS  (N),
    .ACC_WIDTH    (W),
    .LOCK_CYCLES  (LC),
    .DEFAULT_INCR (24'h404040),
    .DEFAULT_PHASE(24'h000000)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_incr (cfg_incr),
    .cfg_phase(cfg_phase),
    .outclk_en(outclk_en),
    .outclk   (outclk),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] sb_q[$];

  // Reference model: 0=SETTLE 1=APPLY 2=LOCKED
  logic [W-1:0] m_acc[N];
  logic [W-1:0] m_incr[N];
  int           m_state = 0;
  int           m_cnt = 0;
  int           m_cchan = 0;
  logic [W-1:0] m_cincr = '0;
  logic [W-1:0] m_cphase = '0;
  logic [N-1:0] m_en = '0;
  logic [N-1:0] m_clk = '0;
  logic         m_locked = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input int ch,
                            input logic [W-1:0] inc, input logic [W-1:0] ph);
    int nxt;
    logic [W:0] sum;
    logic [W-1:0] cur, ic;
    bit ld;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_acc[i]  = '0;
        m_incr[i] = 8'd64;
      end
      m_en = '0; m_clk = '0; m_locked = 1'b0; m_state = 0; m_cnt = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ld  = (m_state == 1) && (m_cchan == i);
        cur = ld ? m_cphase : m_acc[i];
        ic  = ld ? m_cincr : m_incr[i];
        sum = {1'b0, cur} + {1'b0, ic};
        m_en[i]   = sum[W] && !ld;
        m_clk[i]  = cur[W-1];
        m_acc[i]  = sum[W-1:0];
        m_incr[i] = ic;
      end
      nxt = m_state;
      if (m_state == 1) begin
        nxt = 0; m_cnt = 0;
      end else if (v && ch < N) begin
        nxt = 1; m_cchan = ch; m_cincr = inc; m_cphase = ph;
      end else if (m_state == 0) begin
        if (m_cnt == LC - 1) nxt = 2;
        else m_cnt++;
      end
      m_state  = nxt;
      m_locked = (nxt == 2);
    end
    sb_q.push_back({m_en, m_clk, m_locked, m_state != 1});
  endtask

  task automatic tick(input logic r, input logic v, input int ch,
                      input logic [W-1:0] inc, input logic [W-1:0] ph);
    logic [7:0] exp;
    rst = r; cfg_valid = v; cfg_chan = 2'(ch); cfg_incr = inc; cfg_phase = ph;
    model_step(r, v, ch, inc, ph);
    @(posedge refclk);
    #1;
    if (r) cyc = 0;
    else   cyc++;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk("outputs", 32'({outclk_en, outclk, locked, cfg_ready}), 32'(exp));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    int a, first, prev, cnt_s, changes, last_acc;
    logic held;
    int strobes[$];
    int acc_cyc[$];

    // Reset defaults
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 0, '0, '0);
    chk("rst_en", 32'(outclk_en), 32'd0);
    chk("rst_clk", 32'(outclk), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 0, '0, '0);
      if (cyc == 3)  chk("clk_c3", 32'(outclk), 32'd7);
      if (cyc == 4)  chk("en_c4", 32'(outclk_en), 32'd7);
      if (cyc == 5)  chk("en_c5", 32'(outclk_en), 32'd0);
      if (cyc == 8)  chk("en_c8", 32'(outclk_en), 32'd7);
      if (cyc == 15) chk("lock_c15", 32'(locked), 32'd0);
      if (cyc == 16) chk("lock_c16", 32'(locked), 32'd1);
    end

    // Reprogram channel 1 to incr=32
    a = cyc;
    tick(1'b0, 1'b1, 1, 8'd32, 8'd0);
    chk("apply_ready", 32'(cfg_ready), 32'd0);
    chk("apply_locked", 32'(locked), 32'd0);
    first = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 0, '0, '0);
      if (first < 0 && outclk_en[1]) first = cyc;
      if (cyc == a + 2)  chk("ready_back", 32'(cfg_ready), 32'd1);
      if (cyc == a + 17) chk("relock_early", 32'(locked), 32'd0);
      if (cyc == a + 18) chk("relock", 32'(locked), 32'd1);
    end
    chk("ch1_first_strobe", 32'(first), 32'(a + 9));

    // Fractional rate on channel 1
    tick(1'b0, 1'b1, 1, 8'd3, 8'd0);
    for (int i = 0; i < 900; i++) begin
      tick(1'b0, 1'b0, 0, '0, '0);
      if (outclk_en[1]) strobes.push_back(cyc);
    end
    cnt_s = 0;
    if (strobes.size() > 0) begin
      foreach (strobes[k]) if (strobes[k] < strobes[0] + 768) cnt_s++;
    end
    chk("frac_count", 32'(cnt_s), 32'd9);
    for (int k = 1; k < 9 && k < strobes.size(); k++)
      chk("frac_gap", 32'((strobes[k] - strobes[k-1] == 85) || (strobes[k] - strobes[k-1] == 86)), 32'd1);

    // Zero increment on channel 2
    tick(1'b0, 1'b1, 2, 8'd0, 8'd0);
    idle(3);
    held = outclk[2];
    cnt_s = 0; changes = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b0, 0, '0, '0);
      if (outclk_en[2]) cnt_s++;
      if (outclk[2] != held) changes++;
    end
    chk("zero_strobes", 32'(cnt_s), 32'd0);
    chk("zero_clk_const", 32'(changes), 32'd0);

    // Bad channel
    chk("bad_pre_locked", 32'(locked), 32'd1);
    tick(1'b0, 1'b1, 3, 8'h55, 8'h10);
    chk("bad_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 0, '0, '0);
      chk("bad_locked", 32'(locked), 32'd1);
    end

    // Back-to-back requests during SETTLE
    tick(1'b0, 1'b1, 0, 8'd64, 8'd0);
    for (int i = 0; i < 12 && acc_cyc.size() < 3; i++) begin
      if (cfg_ready) acc_cyc.push_back(cyc);
      tick(1'b0, 1'b1, 0, 8'(32 * (acc_cyc.size() + 1)), 8'd0);
    end
    chk("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("b2b_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);
    last_acc = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] : 0;
    first = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 0, '0, '0);
      if (first < 0 && locked) first = cyc;
    end
    chk("b2b_lock", 32'(first), 32'(last_acc + 2 + LC));

    // Reset during APPLY
    tick(1'b0, 1'b1, 0, 8'd10, 8'd99);
    tick(1'b1, 1'b0, 0, '0, '0);
    chk("rst2_en", 32'(outclk_en), 32'd0);
    chk("rst2_clk", 32'(outclk), 32'd0);
    chk("rst2_locked", 32'(locked), 32'd0);
    chk("rst2_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 0, '0, '0);
      if (cyc == 4) chk("rst2_en_c4", 32'(outclk_en), 32'd7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_feed_clk_en_gen.md
# audio_feed_clk_en_gen

Parametrised, fully synchronous clock-enable generator for the audio feed path. It produces `NUM_OUTPUTS` independent rate strobes and square waves from one reference clock. Each channel is a phase-accumulator NCO, so ratios are fractional and can be reprogrammed at run time without a PLL relock. A settle sequencer drives `locked`, which downstream audio/SDRAM logic uses as its go signal.

## Interface
Parameters:
- `NUM_OUTPUTS`, 3: number of channels, 1..16.
- `ACC_WIDTH`, 32: accumulator width W, 8..48.
- `LOCK_CYCLES`, 16: `refclk` cycles in SETTLE before `locked` rises, ≥1.
- `DEFAULT_INCR`, all channels 2^(W-1): packed NUM_OUTPUTS*W reset increments. Channel i is at bits [i*W +: W].
- `DEFAULT_PHASE`, 0: packed NUM_OUTPUTS*W reset accumulator values.

Ports (CHW = max(1, clog2(NUM_OUTPUTS))):
- `refclk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accept.
- `cfg_chan` in CHW: target channel.
- `cfg_incr` in W: new increment.
- `cfg_phase` in W: new accumulator start value.
- `outclk_en` out NUM_OUTPUTS: one-cycle strobe per channel, on accumulator wrap.
- `outclk` out NUM_OUTPUTS: registered accumulator MSB per channel, i.e. a square wave.
- `locked` out 1: configuration stable.

## Operation
- Per channel, every cycle: acc_i ← (acc_i + incr_i) mod 2^W. carry_i = the carry out of that add.
- Strobe and square wave:
  - `outclk_en[i]` ← carry_i, registered.
  - `outclk[i]` ← acc_i[W-1], sampled before the add.
- Output frequency f_i = f_refclk · incr_i / 2^W.
- incr_i = 0: the accumulator holds, no strobes, and `outclk[i]` stays constant.
- State machine states: SETTLE, APPLY, LOCKED.
  - SETTLE: a counter counts 0..LOCK_CYCLES-1, then the state moves to LOCKED.
  - LOCKED: idle until a config request is accepted.
  - APPLY: lasts exactly one cycle, then goes to SETTLE with the counter cleared.
- `cfg_ready` = (state ≠ APPLY).
- `locked` = 1 only in LOCKED, registered from the state.
- Accept: `cfg_valid`&&`cfg_ready` in SETTLE or LOCKED captures chan/incr/phase and moves to APPLY.
- In APPLY, for the target channel:
  - incr ← captured incr;
  - acc ← captured phase, overriding the add;
  - the carry is forced to 0, so no strobe is generated from the APPLY cycle.
- Other channels run undisturbed throughout.
- An accept during SETTLE restarts the settle count after APPLY.
- `cfg_chan` ≥ NUM_OUTPUTS: the request is accepted and its data discarded. No APPLY, no lock drop; the state machine stays in its current state.
- Reset has priority over everything, including an in-flight APPLY; that config is lost.

## Timing
- Reset values:
  - acc = DEFAULT_PHASE;
  - incr = DEFAULT_INCR;
  - `outclk_en` = 0, `outclk` = 0, `locked` = 0, `cfg_ready` = 1;
  - state = SETTLE, counter = 0.
- Cycle 0 is the first cycle with `rst` low; the first add happens at cycle 0.
- Strobe latency: a carry generated in cycle k gives `outclk_en` high in cycle k+1, for exactly one cycle.
- Lock timing: `locked` rises in cycle LOCK_CYCLES after reset release or after APPLY.
- Config timing:
  - accept in cycle a → APPLY in a+1 → `locked` = 0 from a+1;
  - `locked` = 1 again at a+2+LOCK_CYCLES;
  - `cfg_ready` = 0 in a+1 only.
- Sustained request rate: `cfg_valid` held high gives one accept every 2 cycles.
- Registered outputs: all outputs are registered, with no combinational path from `cfg_*` to outputs. Exception: `cfg_ready` decodes the state register only.

## Structure
- Package `audio_feed_clk_pkg`:
  - state enum {SETTLE, APPLY, LOCKED};
  - a `chan_w` function (CHW);
  - the channel count and accumulator width limits as constants.
- Sub-module `audio_feed_nco_chan`: one accumulator, increment register, load port, carry/MSB output registers. It is generated NUM_OUTPUTS times.
- The top level holds the state machine, the settle counter, the config capture and the channel decode.

## Test plan
- **Reset defaults.** W=8, NUM_OUTPUTS=3, incr all 64, phase 0, LOCK_CYCLES=16, release `rst` at cycle 0.
  - `outclk_en[i]` high at cycles 4, 8, 12, ….
  - `outclk[i]` high in cycles 3–4, 7–8, ….
  - `locked` rises at cycle 16.
- **Reprogram one channel.** In LOCKED, accept chan=1, incr=32, phase=0 at cycle a.
  - `locked` = 0 from a+1 to a+17 and rises at a+18.
  - `cfg_ready` = 0 at a+1 only.
  - Channel 1 strobes first at a+9, then every 8 cycles.
  - Channels 0 and 2 are unchanged.
- **Fractional rate.** W=8, incr=3, run 256·3 cycles.
  - Exactly 3 strobes per 256 cycles.
  - Strobe spacing alternates 85/85/86.
- **Zero increment and bad channel.**
  - incr=0 on chan 2: no strobes, `outclk[2]` constant.
  - cfg_chan=3: accepted, `locked` stays 1, no channel changes.
- **Back-to-back requests.** `cfg_valid` held high during SETTLE with 3 requests.
  - Accepts every 2nd cycle.
  - The settle count restarts after each APPLY.
  - `locked` rises LOCK_CYCLES cycles after the last APPLY.
- **Reset mid-APPLY.** Assert `rst` in the APPLY cycle.
  - All outputs return to their reset values.
  - DEFAULT_INCR is restored and the config is lost.
